// File: rtl/hdmi_sched_pkg.sv
// Shared constants for the HDMI frame scheduler.
// FSM state codes and the frame-bank base address helper.
package hdmi_sched_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_FLUSH = 3'd1;
   localparam logic [2:0] ST_WAIT  = 3'd2;
   localparam logic [2:0] ST_REQ   = 3'd3;
   localparam logic [2:0] ST_BUSY  = 3'd4;
   localparam logic [2:0] ST_DONE  = 3'd5;

   function automatic logic [31:0] bank_base(
      input logic bank,
      input int   shift
   );
      return {31'd0, bank} << shift;
   endfunction

endpackage

// File: rtl/hdmi_bank_ctrl.sv
// Frame-start edge detect and ping-pong bank ownership.
// Swaps banks at frame start when the writer has a finished frame.
module hdmi_bank_ctrl
   import hdmi_sched_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic video_vs,
   input  logic wr_frame_done,
   output logic fs,
   output logic rd_bank,
   output logic wr_bank,
   output logic wr_hold
);

   logic vs_q, vs_d;
   logic pend_q, pend_d;
   logic rd_bank_q, rd_bank_d;
   logic wr_bank_q, wr_bank_d;

   always_comb begin
      vs_d      = video_vs;
      fs        = video_vs & ~vs_q;
      pend_d    = pend_q;
      rd_bank_d = rd_bank_q;
      wr_bank_d = wr_bank_q;
      if (fs) begin
         // a done pulse coinciding with fs still counts
         if (pend_q | wr_frame_done) begin
            rd_bank_d = wr_bank_q;
            wr_bank_d = ~wr_bank_q;
         end
         pend_d = 1'b0;
      end else if (wr_frame_done) begin
         pend_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_q      <= 1'b1;
         pend_q    <= 1'b0;
         rd_bank_q <= 1'b0;
         wr_bank_q <= 1'b1;
      end else begin
         vs_q      <= vs_d;
         pend_q    <= pend_d;
         rd_bank_q <= rd_bank_d;
         wr_bank_q <= wr_bank_d;
      end
   end

   assign rd_bank = rd_bank_q;
   assign wr_bank = wr_bank_q;
   assign wr_hold = pend_q;

endmodule

// File: rtl/hdmi_frame_scheduler.sv
// Display read-path sequencer: flushes the read FIFO at frame start,
// then issues one burst read per line, throttled by FIFO free space.
module hdmi_frame_scheduler
   import hdmi_sched_pkg::*;
#(
   parameter int ADDR_W     = 24,
   parameter int BANK_SHIFT = 21,
   parameter int FIFO_AW    = 11
) (
   input  logic               hdmi_clk,
   input  logic               rst_n,
   input  logic               video_vs,
   input  logic [10:0]        h_disp,
   input  logic [10:0]        v_disp,
   input  logic               wr_frame_done,
   input  logic [FIFO_AW-1:0] fifo_room,
   input  logic               line_ack,
   input  logic               line_done,
   output logic               line_req,
   output logic [ADDR_W-1:0]  line_addr,
   output logic [10:0]        line_len,
   output logic               rd_flush,
   output logic               rd_bank,
   output logic               wr_bank,
   output logic               wr_hold,
   output logic               frame_err
);

   logic              fs;
   logic [2:0]        state_q, state_d;
   logic [10:0]       cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [10:0]       len_q, len_d;
   logic              err_q, err_d;
   logic              restart_q, restart_d;
   logic              room_ok;
   logic [10:0]       cnt_inc;
   logic [ADDR_W-1:0] base;

   hdmi_bank_ctrl u_bank (
      .clk           (hdmi_clk),
      .rst_n         (rst_n),
      .video_vs      (video_vs),
      .wr_frame_done (wr_frame_done),
      .fs            (fs),
      .rd_bank       (rd_bank),
      .wr_bank       (wr_bank),
      .wr_hold       (wr_hold)
   );

   assign room_ok = 32'(fifo_room) >= 32'(h_disp);
   assign cnt_inc = cnt_q + 11'd1;
   assign base    = ADDR_W'(bank_base(rd_bank, BANK_SHIFT));

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      len_d     = len_q;
      err_d     = err_q;
      restart_d = restart_q;
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (fs) state_d = ST_FLUSH;
         end
         ST_FLUSH: begin
            cnt_d     = '0;
            addr_d    = base;
            len_d     = h_disp;
            restart_d = 1'b0;
            // room read here is pre-flush, so it can only under-estimate
            if (v_disp == 11'd0) state_d = ST_DONE;
            else if (room_ok)    state_d = ST_REQ;
            else                 state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (fs) begin
               err_d   = 1'b1;
               state_d = ST_FLUSH;
            end else if (room_ok) begin
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (line_ack) begin
               state_d = ST_BUSY;
               if (fs) begin
                  err_d     = 1'b1;
                  restart_d = 1'b1;
               end
            end else if (fs) begin
               err_d   = 1'b1;
               state_d = ST_FLUSH;
            end
         end
         ST_BUSY: begin
            if (fs) begin
               err_d     = 1'b1;
               restart_d = 1'b1;
            end
            // a burst in flight is always allowed to land before a flush
            if (line_done) begin
               cnt_d  = cnt_inc;
               addr_d = addr_q + ADDR_W'(h_disp);
               if (restart_q | fs)       state_d = ST_FLUSH;
               else if (cnt_inc == v_disp) state_d = ST_DONE;
               else                      state_d = ST_WAIT;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge hdmi_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         addr_q    <= '0;
         len_q     <= '0;
         err_q     <= 1'b0;
         restart_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         len_q     <= len_d;
         err_q     <= err_d;
         restart_q <= restart_d;
      end
   end

   assign line_req  = (state_q == ST_REQ);
   assign rd_flush  = (state_q == ST_FLUSH);
   assign line_addr = addr_q;
   assign line_len  = len_q;
   assign frame_err = err_q;

endmodule

// File: tb/tb_hdmi_frame_scheduler.sv
// Scoreboard bench for hdmi_frame_scheduler: expected bursts are queued
// by the stimulus and popped by a monitor on every accepted request.
module tb_hdmi_frame_scheduler;

   logic        hdmi_clk = 1'b0;
   logic        rst_n;
   logic        video_vs;
   logic [10:0] h_disp;
   logic [10:0] v_disp;
   logic        wr_frame_done;
   logic [10:0] fifo_room;
   logic        line_ack;
   logic        line_done;
   logic        line_req;
   logic [23:0] line_addr;
   logic [10:0] line_len;
   logic        rd_flush;
   logic        rd_bank;
   logic        wr_bank;
   logic        wr_hold;
   logic        frame_err;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] len;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   bit   auto_mem  = 1'b0;
   bit   done_own  = 1'b0;
   int   busy_cnt  = 0;
   int   acked_cnt = 0;
   int   hold_line = -1;

   always #5 hdmi_clk = ~hdmi_clk;

   hdmi_frame_scheduler dut (
      .hdmi_clk      (hdmi_clk),
      .rst_n         (rst_n),
      .video_vs      (video_vs),
      .h_disp        (h_disp),
      .v_disp        (v_disp),
      .wr_frame_done (wr_frame_done),
      .fifo_room     (fifo_room),
      .line_ack      (line_ack),
      .line_done     (line_done),
      .line_req      (line_req),
      .line_addr     (line_addr),
      .line_len      (line_len),
      .rd_flush      (rd_flush),
      .rd_bank       (rd_bank),
      .wr_bank       (wr_bank),
      .wr_hold       (wr_hold),
      .frame_err     (frame_err)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge hdmi_clk);
   endtask

   task automatic push_frame(input logic [31:0] base, input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.addr = (base + i * 1024) & 32'h00FF_FFFF;
         e.len  = 32'd1024;
         exp_q.push_back(e);
      end
   endtask

   task automatic frame_start();
      video_vs = 1'b0;
      tick(5);
      video_vs = 1'b1;
      tick(1);
      chk("rd_flush_at_fs_plus1", rd_flush, 1);
   endtask

   task automatic wait_empty(input int limit);
      for (int i = 0; i < limit && exp_q.size() > 0; i++) tick(1);
      chk("queue_drained", exp_q.size(), 0);
   endtask

   // memory port model, acting mid-cycle away from both clock edges
   initial begin
      forever begin
         @(posedge hdmi_clk);
         #2;
         if (done_own) begin
            line_done = 1'b0;
            done_own  = 1'b0;
         end
         if (auto_mem) begin
            if (line_ack) begin
               line_ack = 1'b0;
               busy_cnt = 3;
            end else if (busy_cnt > 0) begin
               if (!(busy_cnt == 1 && hold_line >= 0 &&
                     acked_cnt == hold_line + 1)) begin
                  busy_cnt--;
                  if (busy_cnt == 0) begin
                     line_done = 1'b1;
                     done_own  = 1'b1;
                  end
               end
            end else if (line_req) begin
               line_ack = 1'b1;
               acked_cnt++;
            end
         end
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge hdmi_clk);
         #1;
         if (rst_n && line_req && line_ack) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_req: addr %0h len %0d",
                        line_addr, line_len);
            end else begin
               e = exp_q.pop_front();
               chk("req_addr", line_addr, e.addr);
               chk("req_len", line_len, e.len);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: sim time %0t exceeded", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      bit bad;
      logic [23:0] a0;
      rst_n         = 1'b0;
      video_vs      = 1'b1;
      h_disp        = 11'd1024;
      v_disp        = 11'd768;
      wr_frame_done = 1'b0;
      fifo_room     = 11'd2047;
      line_ack      = 1'b0;
      line_done     = 1'b0;
      tick(3);
      chk("rst_line_req", line_req, 0);
      chk("rst_line_addr", line_addr, 0);
      chk("rst_line_len", line_len, 0);
      chk("rst_rd_flush", rd_flush, 0);
      chk("rst_rd_bank", rd_bank, 0);
      chk("rst_wr_bank", wr_bank, 1);
      chk("rst_wr_hold", wr_hold, 0);
      chk("rst_frame_err", frame_err, 0);
      rst_n = 1'b1;
      tick(3);
      chk("no_flush_after_rst", rd_flush, 0);

      // full 1024x768 frame from bank 0
      push_frame(32'h0, 768);
      auto_mem = 1'b1;
      frame_start();
      tick(1);
      chk("first_req_at_fs_plus2", line_req, 1);
      wait_empty(768 * 10);
      tick(10);
      chk("idle_after_frame", line_req, 0);
      chk("no_err_frame1", frame_err, 0);

      // writer finishes a frame mid-display
      v_disp = 11'd4;
      push_frame(32'h0, 4);
      frame_start();
      wr_frame_done = 1'b1;
      tick(1);
      wr_frame_done = 1'b0;
      chk("wr_hold_after_done", wr_hold, 1);
      chk("rd_bank_before_swap", rd_bank, 0);
      wait_empty(100);
      tick(5);
      chk("wr_hold_until_fs", wr_hold, 1);

      push_frame(32'h20_0000, 4);
      frame_start();
      chk("rd_bank_swapped", rd_bank, 1);
      chk("wr_bank_swapped", wr_bank, 0);
      chk("wr_hold_cleared", wr_hold, 0);
      wait_empty(100);

      push_frame(32'h20_0000, 4);
      frame_start();
      chk("rd_bank_repeat", rd_bank, 1);
      wait_empty(100);
      tick(5);

      // FIFO room throttling
      fifo_room = 11'd1000;
      push_frame(32'h20_0000, 4);
      frame_start();
      tick(1);
      chk("no_req_low_room", line_req, 0);
      tick(5);
      chk("no_req_low_room_later", line_req, 0);
      fifo_room = 11'd1024;
      tick(1);
      chk("req_after_room", line_req, 1);
      wait_empty(100);
      tick(5);

      // request held stable while ack is withheld
      fifo_room = 11'd2047;
      auto_mem  = 1'b0;
      push_frame(32'h20_0000, 4);
      frame_start();
      tick(1);
      a0  = line_addr;
      bad = 1'b0;
      for (int i = 0; i < 50; i++) begin
         tick(1);
         if (!line_req || line_addr !== a0 || line_len !== 11'd1024)
            bad = 1'b1;
      end
      chk("req_stable_50", bad, 0);
      line_ack = 1'b1;
      tick(1);
      line_ack = 1'b0;
      chk("req_drop_after_ack", line_req, 0);
      tick(2);
      line_done = 1'b1;
      tick(1);
      line_done = 1'b0;
      auto_mem = 1'b1;
      wait_empty(100);
      tick(5);

      // frame start while a burst is in flight at line 300
      v_disp    = 11'd768;
      acked_cnt = 0;
      hold_line = 300;
      push_frame(32'h20_0000, 301);
      frame_start();
      for (int i = 0; i < 4000 && acked_cnt < 301; i++) tick(1);
      chk("hold_line_reached", acked_cnt, 301);
      tick(3);
      video_vs = 1'b0;
      tick(5);
      video_vs = 1'b1;
      tick(1);
      chk("busy_fs_no_flush", rd_flush, 0);
      chk("busy_fs_err", frame_err, 1);
      tick(4);
      chk("busy_fs_still_no_flush", rd_flush, 0);
      v_disp = 11'd4;
      push_frame(32'h20_0000, 4);
      busy_cnt  = 0;
      hold_line = -1;
      line_done = 1'b1;
      tick(1);
      line_done = 1'b0;
      chk("flush_after_line_done", rd_flush, 1);
      wait_empty(100);
      tick(10);
      chk("restart_frame_idle", line_req, 0);
      chk("err_sticky", frame_err, 1);

      // asynchronous reset while requesting
      auto_mem = 1'b0;
      frame_start();
      tick(1);
      chk("in_req_before_rst", line_req, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_line_req", line_req, 0);
      chk("async_rst_addr", line_addr, 0);
      chk("async_rst_err", frame_err, 0);
      chk("async_rst_rd_bank", rd_bank, 0);
      chk("async_rst_wr_bank", wr_bank, 1);
      tick(2);
      rst_n = 1'b1;
      bad   = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick(1);
         if (rd_flush) bad = 1'b1;
      end
      chk("no_flush_after_rerst", bad, 0);
      push_frame(32'h0, 4);
      auto_mem = 1'b1;
      frame_start();
      wait_empty(100);
      tick(5);
      chk("final_err_clear", frame_err, 0);
      chk("final_rd_bank", rd_bank, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
